pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// Parametrised program-counter sequencer; successor to the single-target fetch PC.
// Adds the following over that design:
//   - encoded branch conditions
//   - absolute or PC-relative targets
//   - call/return through a hardware return-address stack (RAS)
//   - pipeline stall
//   - explicit RUN/HALT state with a sticky stack-error flag
// Sits between decode/ALU (condition, target, control) and instruction memory (ProgCtr).
// PARAMETERS
// T      10  PC / instruction address width
// W      8   target field width (W <= T); absolute = zero-extend, relative = sign-extend
// D      4   RAS depth, in entries (D >= 1)
// PORTS
// Clk         in   1       clock, rising edge
// Reset       in   1       synchronous, active-high
// Stall       in   1       hold PC and state this cycle (no stack change)
// Done        in   1       current instruction is final; halt unless redirected
// BrEn        in   1       conditional/unconditional branch request
// BrCond      in   2       cond_e: ALWAYS=00, EZ=01, NZ=10, NEVER=11
// BrRel       in   1       1 = PC-relative target, 0 = absolute (branch only)
// Call        in   1       push ProgCtr+1, jump to absolute Target
// Ret         in   1       pop RAS into PC
// Zero        in   1       ALU zero flag
// Target      in   W       jump target / signed offset
// ProgCtr     out  T       current PC to instruction memory
// ProgCtr_p1  out  T       ProgCtr+1 (mod 2^T), combinational
// Halted      out  1       1 in HALT state
// StackErr    out  1       sticky: RAS overflow or underflow occurred
// BEHAVIOUR
// Reset values:
//   - ProgCtr=0, state=RUN, Halted=0, StackErr=0, RAS pointer=0 (empty)
// All updates on posedge Clk.
// Redirect and PC update:
//   - Next PC is visible the cycle after the request (1-cycle latency).
//   - Taken: BrEn & (ALWAYS | EZ&Zero | NZ&!Zero). NEVER is never taken.
//   - Targets: abs = {0,Target}; rel = ProgCtr + sext(Target).
//   - All PC arithmetic wraps mod 2^T; no overflow flag.
// Priority, evaluated in RUN only:
//   1. Reset
//   2. Stall: everything holds, including Done.
//   3. Ret
//   4. Call
//   5. taken branch
//   6. Done
//   7. increment
//   Lower-priority requests in the same cycle are dropped:
//   - Call&Ret: Ret executes, Call ignored.
//   - Call&BrEn: Call executes.
// Ret:
//   - RAS non-empty: PC <= top, pop.
//   - RAS empty: StackErr <= 1, state <= HALT, PC holds.
// Call:
//   - RAS not full: push ProgCtr+1, PC <= abs Target.
//   - RAS full (D entries): StackErr <= 1, state <= HALT, no push, PC holds.
// Done:
//   - With no redirect: state <= HALT, PC holds.
//   - With a taken redirect: the redirect wins, state stays RUN.
// HALT:
//   - PC, RAS and StackErr frozen; all inputs ignored.
//   - Exit only by Reset.
// StackErr clears only on Reset. Reset mid-operation discards RAS contents.
// States: RUN -> HALT on (Done & no redirect) | overflow | underflow.
//         HALT -> RUN on Reset only.
// STRUCTURE
// fetch_pkg:
//   - cond_e (2-bit enum)
//   - state_e {RUN, HALT}
//   - default widths T_DEF=10, W_DEF=8, D_DEF=4
// Sub-module ret_stack #(T,D):
//   - push/pop, full/empty, top
//   - $clog2(D+1)-bit pointer
//   - synchronous reset clears pointer
// Top level holds the PC register, target mux, taken logic and FSM.
// TESTING
// 1. Reset then 5 idle cycles -> ProgCtr 0,1,2,3,4,5; Halted=0.
// 2. PC=20:
//    - BrEn,EZ,Zero=1,abs Target=8'h40 -> PC=64.
//    - Same with Zero=0 -> PC=21.
//    - NEVER -> 21.
// 3. PC=3, BrRel, Target=8'hFB (-5) -> PC=1022 (wrap, T=10).
// 4. Nested calls, PC=10 Call T=50, then at 50 Call T=80, Ret, Ret:
//    - PC sequence 10 -> 50 -> 80 -> 51 -> 11.
//    - RAS empty after, StackErr=0.
// 5. Push overflow/underflow:
//    - 4 calls, then 5th Call -> StackErr=1, Halted=1, PC frozen.
//    - After Reset, Ret on empty -> StackErr=1, Halted.
// 6. Stall/Done priority:
//    - Stall with BrEn ALWAYS -> PC unchanged, redirect lost.
//    - Done & taken branch -> PC=Target, Halted=0.
//    - Done alone -> Halted=1; Reset mid-HALT -> PC=0, RUN.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the PC sequencer
package fetch_pkg;

    // Branch condition encoding carried on BrCond
    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_EZ     = 2'b01,
        COND_NZ     = 2'b10,
        COND_NEVER  = 2'b11
    } cond_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam int T_DEF = 10;  // PC / instruction address width
    localparam int W_DEF = 8;   // target field width
    localparam int D_DEF = 4;   // return-address stack depth

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode/ALU <-> PC sequencer signal bundle
// master: decode side, drives control/condition/target, observes PC and status
// slave : sequencer, consumes control, drives ProgCtr, ProgCtr_p1, Halted, StackErr
interface pc_sequencer_if #(
    parameter int T = fetch_pkg::T_DEF,
    parameter int W = fetch_pkg::W_DEF
);
    logic         Stall;
    logic         Done;
    logic         BrEn;
    logic [1:0]   BrCond;
    logic         BrRel;
    logic         Call;
    logic         Ret;
    logic         Zero;
    logic [W-1:0] Target;
    logic [T-1:0] ProgCtr;
    logic [T-1:0] ProgCtr_p1;
    logic         Halted;
    logic         StackErr;

    modport master (
        output Stall, Done, BrEn, BrCond, BrRel, Call, Ret, Zero, Target,
        input  ProgCtr, ProgCtr_p1, Halted, StackErr
    );

    modport slave (
        input  Stall, Done, BrEn, BrCond, BrRel, Call, Ret, Zero, Target,
        output ProgCtr, ProgCtr_p1, Halted, StackErr
    );
endinterface

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - hardware return-address stack
// Ports: clk, rst (sync, active-high, clears pointer), push/push_data,
//        pop, full, empty, top (entry that the next pop returns).
// push and pop must not be asserted together; the caller guards against
// pushing when full and popping when empty.
module ret_stack #(
    parameter int T = 10,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [T-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [T-1:0] top
);
    localparam int PW = $clog2(D + 1);
    // Storage is rounded up to a power of two so the address is exactly AW bits
    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int NE = 1 << AW;

    logic [PW-1:0] ptr_q;
    logic [T-1:0]  mem_q [NE];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign empty  = (ptr_q == '0);
    assign full   = (ptr_q == PW'(D));
    assign wr_idx = AW'(ptr_q);
    assign rd_idx = AW'(ptr_q - PW'(1));
    assign top    = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PW'(1);
        end else if (pop) begin
            ptr_q <= ptr_q - PW'(1);
        end
    end

    // Entries need no reset: an empty pointer makes them unreachable
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with branches, call/return and halt
// Ports: Clk, Reset (sync, active-high), bus (pc_sequencer_if.slave):
//   in : Stall, Done, BrEn, BrCond, BrRel, Call, Ret, Zero, Target
//   out: ProgCtr, ProgCtr_p1, Halted, StackErr
module pc_sequencer
    import fetch_pkg::*;
#(
    parameter int T = T_DEF,
    parameter int W = W_DEF,
    parameter int D = D_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_sequencer_if.slave  bus
);
    logic [T-1:0] pc_q, pc_d;
    state_e       state_q, state_d;
    logic         err_q, err_d;

    logic         ras_push, ras_pop;
    logic         ras_full, ras_empty;
    logic [T-1:0] ras_top;

    logic [T-1:0] pc_p1;
    logic [T-1:0] tgt_abs;
    logic [T-1:0] tgt_rel;
    logic [T-1:0] br_tgt;
    logic         taken;
    cond_e        cond;

    assign pc_p1   = pc_q + T'(1);
    assign tgt_abs = T'(bus.Target);
    assign tgt_rel = pc_q + T'($signed(bus.Target));
    assign br_tgt  = bus.BrRel ? tgt_rel : tgt_abs;
    assign cond    = cond_e'(bus.BrCond);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_ALWAYS: taken = bus.BrEn;
            COND_EZ:     taken = bus.BrEn &  bus.Zero;
            COND_NZ:     taken = bus.BrEn & ~bus.Zero;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

    // Priority chain: Stall > Ret > Call > taken branch > Done > increment.
    // A stack fault halts with the PC left where it was.
    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        err_d    = err_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (state_q == ST_RUN && !bus.Stall) begin
            if (bus.Ret) begin
                if (!ras_empty) begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end else if (bus.Call) begin
                if (!ras_full) begin
                    pc_d     = tgt_abs;
                    ras_push = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end else if (taken) begin
                pc_d = br_tgt;
            end else if (bus.Done) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_p1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= '0;
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    ret_stack #(
        .T (T),
        .D (D)
    ) u_ras (
        .clk       (Clk),
        .rst       (Reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_p1),
        .full      (ras_full),
        .empty     (ras_empty),
        .top       (ras_top)
    );

    assign bus.ProgCtr    = pc_q;
    assign bus.ProgCtr_p1 = pc_p1;
    assign bus.Halted     = (state_q == ST_HALT);
    assign bus.StackErr   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
    localparam int T = 10;
    localparam int W = 8;
    localparam int D = 4;
    localparam int MODV = 1 << T;

    logic Clk;
    logic Reset;

    pc_sequencer_if #(.T(T), .W(W)) bus ();

    pc_sequencer #(.T(T), .W(W), .D(D)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: integer PC, queue as stack, flags
    int m_pc    = 0;
    bit m_halt  = 0;
    bit m_err   = 0;
    bit m_valid = 0;
    int m_ras[$];

    function automatic bit m_taken(logic en, logic [1:0] c, logic z);
        if (!en) return 0;
        if (c == 2'd0) return 1;
        if (c == 2'd1) return z;
        if (c == 2'd2) return !z;
        return 0;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_pc = 0; m_halt = 0; m_err = 0; m_ras.delete(); m_valid = 1;
        end else if (m_valid && !m_halt && !bus.Stall) begin
            if (bus.Ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_err = 1; m_halt = 1; end
            end else if (bus.Call) begin
                if (m_ras.size() < D) begin
                    m_ras.push_back((m_pc + 1) % MODV);
                    m_pc = int'(bus.Target);
                end else begin m_err = 1; m_halt = 1; end
            end else if (m_taken(bus.BrEn, bus.BrCond, bus.Zero)) begin
                if (bus.BrRel) begin
                    int off;
                    off = int'(bus.Target);
                    if (off >= (1 << (W - 1))) off -= (1 << W);
                    m_pc = ((m_pc + off) % MODV + MODV) % MODV;
                end else begin
                    m_pc = int'(bus.Target);
                end
            end else if (bus.Done) begin
                m_halt = 1;
            end else begin
                m_pc = (m_pc + 1) % MODV;
            end
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            chk("cyc_pc",   int'(bus.ProgCtr),    m_pc);
            chk("cyc_pc1",  int'(bus.ProgCtr_p1), (m_pc + 1) % MODV);
            chk("cyc_halt", int'(bus.Halted),     int'(m_halt));
            chk("cyc_err",  int'(bus.StackErr),   int'(m_err));
        end
    end

    task automatic clear_in();
        bus.Stall = 0; bus.Done = 0; bus.BrEn = 0; bus.BrCond = 2'd0;
        bus.BrRel = 0; bus.Call = 0; bus.Ret = 0; bus.Zero = 0; bus.Target = '0;
    endtask

    task automatic cyc(input logic st, input logic dn, input logic be, input logic [1:0] cd,
                       input logic rl, input logic cl, input logic rt, input logic zr,
                       input logic [7:0] tg);
        bus.Stall = st; bus.Done = dn; bus.BrEn = be; bus.BrCond = cd;
        bus.BrRel = rl; bus.Call = cl; bus.Ret = rt; bus.Zero = zr; bus.Target = tg;
        @(posedge Clk); #1;
        clear_in();
    endtask

    task automatic do_reset();
        Reset = 1;
        @(posedge Clk); #1;
        Reset = 0;
    endtask

    task automatic idle();            cyc(0,0,0,2'd0,0,0,0,0,8'd0); endtask
    task automatic jmp(input logic [7:0] t); cyc(0,0,1,2'd0,0,0,0,0,t); endtask
    task automatic call(input logic [7:0] t); cyc(0,0,0,2'd0,0,1,0,0,t); endtask
    task automatic ret();             cyc(0,0,0,2'd0,0,0,1,0,8'd0); endtask

    initial begin
        Reset = 1;
        clear_in();
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 0;

        // 1: reset state and free-running increment
        chk("rst_pc",   int'(bus.ProgCtr), 0);
        chk("rst_halt", int'(bus.Halted), 0);
        chk("rst_err",  int'(bus.StackErr), 0);
        chk("rst_pc1",  int'(bus.ProgCtr_p1), 1);
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("inc_pc", int'(bus.ProgCtr), i);
        end
        chk("inc_halt", int'(bus.Halted), 0);

        // 2: conditional branches from PC=20
        jmp(8'd20);
        chk("jmp20", int'(bus.ProgCtr), 20);
        cyc(0,0,1,2'd1,0,0,0,1,8'h40);
        chk("ez_taken", int'(bus.ProgCtr), 64);
        jmp(8'd20);
        cyc(0,0,1,2'd1,0,0,0,0,8'h40);
        chk("ez_not", int'(bus.ProgCtr), 21);
        jmp(8'd20);
        cyc(0,0,1,2'd3,0,0,0,1,8'h40);
        chk("never", int'(bus.ProgCtr), 21);
        cyc(0,0,1,2'd2,0,0,0,0,8'h33);
        chk("nz_taken", int'(bus.ProgCtr), 51);

        // 3: relative branches with wrap
        jmp(8'd3);
        cyc(0,0,1,2'd0,1,0,0,0,8'hFB);
        chk("rel_neg_wrap", int'(bus.ProgCtr), 1022);
        cyc(0,0,1,2'd0,1,0,0,0,8'h01);
        chk("rel_pos", int'(bus.ProgCtr), 1023);
        chk("pc1_wrap", int'(bus.ProgCtr_p1), 0);
        idle();
        chk("inc_wrap", int'(bus.ProgCtr), 0);
        jmp(8'd254);
        cyc(0,0,1,2'd0,1,0,0,0,8'h7F);
        chk("rel_max", int'(bus.ProgCtr), 381);

        // 4: nested call / return
        jmp(8'd10);
        call(8'd50);
        chk("call1", int'(bus.ProgCtr), 50);
        call(8'd80);
        chk("call2", int'(bus.ProgCtr), 80);
        ret();
        chk("ret1", int'(bus.ProgCtr), 51);
        ret();
        chk("ret2", int'(bus.ProgCtr), 11);
        chk("nest_err", int'(bus.StackErr), 0);
        chk("model_ras_empty", m_ras.size(), 0);

        // 5: overflow, then underflow after reset
        call(8'd100); call(8'd110); call(8'd120); call(8'd130);
        chk("call4", int'(bus.ProgCtr), 130);
        chk("call4_err", int'(bus.StackErr), 0);
        call(8'd140);
        chk("ovf_pc", int'(bus.ProgCtr), 130);
        chk("ovf_err", int'(bus.StackErr), 1);
        chk("ovf_halt", int'(bus.Halted), 1);
        jmp(8'd5);
        chk("halt_frozen", int'(bus.ProgCtr), 130);
        do_reset();
        chk("rst2_pc", int'(bus.ProgCtr), 0);
        chk("rst2_err", int'(bus.StackErr), 0);
        ret();
        chk("unf_pc", int'(bus.ProgCtr), 0);
        chk("unf_err", int'(bus.StackErr), 1);
        chk("unf_halt", int'(bus.Halted), 1);

        // Same-cycle conflicts: Ret beats Call, Call beats branch
        do_reset();
        call(8'd30);
        cyc(0,0,0,2'd0,0,1,1,0,8'd60);
        chk("ret_over_call", int'(bus.ProgCtr), 1);
        cyc(0,0,1,2'd0,0,1,0,0,8'd40);
        chk("call_over_br", int'(bus.ProgCtr), 40);
        ret();
        chk("ret_after", int'(bus.ProgCtr), 2);

        // 6: stall / done priority
        cyc(1,0,1,2'd0,0,0,0,0,8'd90);
        chk("stall_hold", int'(bus.ProgCtr), 2);
        idle();
        chk("stall_lost", int'(bus.ProgCtr), 3);
        cyc(1,1,0,2'd0,0,0,0,0,8'd0);
        chk("stall_done", int'(bus.Halted), 0);
        cyc(0,1,1,2'd0,0,0,0,0,8'd70);
        chk("done_br_pc", int'(bus.ProgCtr), 70);
        chk("done_br_run", int'(bus.Halted), 0);
        cyc(0,1,1,2'd3,0,0,0,0,8'd9);
        chk("done_never_halt", int'(bus.Halted), 1);
        chk("done_pc", int'(bus.ProgCtr), 70);
        idle();
        chk("halt_hold", int'(bus.ProgCtr), 70);
        do_reset();
        chk("rst3_pc", int'(bus.ProgCtr), 0);
        chk("rst3_halt", int'(bus.Halted), 0);
        idle();
        chk("run_again", int'(bus.ProgCtr), 1);

        @(negedge Clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
